ama_riscv_imm_ctrl: RTL

//  Decode-stage controller for the immediate generator. Accepts fetched

---
 rtl/ama_riscv_imm_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ama_riscv_imm_ctrl.sv
// ---------------------------------------------------------------------------
// ama_riscv_imm_ctrl
//
// Decode-stage controller for the immediate generator. Fetched instructions
// arrive over a valid/ready handshake, are classified by opcode into
// ig_en / ig_sel / illegal, and are held together with inst[31:7] in a
// 2-entry elastic (skid) buffer. The buffer supports a synchronous flush,
// a post-reset bubble window during which nothing is accepted, and a
// saturating counter of cycles spent with output valid but not consumed.
//
// Ports
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      asynchronous reset, active-high
//   flush      in   1      synchronous flush (branch redirect)
//   in_valid   in   1      fetch presents in_inst
//   in_ready   out  1      controller can accept in_inst this cycle
//   in_inst    in   32     fetched instruction
//   out_valid  out  1      ig_* / illegal outputs are valid
//   out_ready  in   1      downstream consumes current output
//   ig_en      out  1      immediate generator enable
//   ig_sel     out  4      0 none, 1 I, 2 S, 3 B, 4 J, 5 U
//   ig_in      out  25     instruction bits [31:7]
//   illegal    out  1      unsupported opcode or inst[1:0] != 2'b11
//   stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating
// ---------------------------------------------------------------------------
module ama_riscv_imm_ctrl #(
  parameter int RST_BUBBLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ig_en,
  output logic [3:0]       ig_sel,
  output logic [24:0]      ig_in,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int BW = (RST_BUBBLES > 1) ? $clog2(RST_BUBBLES + 1) : 1;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_EMPTY = 2'd1,
    S_HALF  = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  typedef struct packed {
    logic        en;
    logic [3:0]  sel;
    logic        ill;
    logic [24:0] imm;
  } entry_t;

  // Opcode classification; the immediate payload is carried unchanged.
  function automatic entry_t decode(input logic [31:0] inst);
    entry_t e;
    e.en  = 1'b0;
    e.sel = 4'd0;
    e.ill = 1'b0;
    e.imm = inst[31:7];
    case (inst[6:0])
      7'b0110111, 7'b0010111: begin e.en = 1'b1; e.sel = 4'd5; end
      7'b1101111:             begin e.en = 1'b1; e.sel = 4'd4; end
      7'b1100011:             begin e.en = 1'b1; e.sel = 4'd3; end
      7'b0100011:             begin e.en = 1'b1; e.sel = 4'd2; end
      7'b1100111, 7'b0000011,
      7'b0010011, 7'b1110011: begin e.en = 1'b1; e.sel = 4'd1; end
      7'b0110011, 7'b0001111: ;
      // Every listed opcode ends in 2'b11, so a bad inst[1:0] lands here too.
      default:                e.ill = 1'b1;
    endcase
    return e;
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic [BW-1:0]   r_bub;
  logic            w_bub_done;
  entry_t          r_main;
  entry_t          r_skid;
  entry_t          w_dec;
  logic            w_accept;
  logic            w_deliver;
  logic            w_ld_main_new;
  logic            w_ld_main_skid;
  logic            w_ld_skid;
  logic [CNT_W-1:0] r_stall;

  assign in_ready   = (r_state == S_EMPTY) || (r_state == S_HALF);
  assign out_valid  = (r_state == S_HALF)  || (r_state == S_FULL);
  assign w_accept   = in_valid & in_ready;
  assign w_deliver  = out_valid & out_ready;
  assign w_dec      = decode(in_inst);
  // The counter leaves RESET on the edge where it would reach zero;
  // a zero bubble count leaves on the very first edge.
  assign w_bub_done = (r_bub <= BW'(1));

  // Post-reset bubble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bub <= BW'(RST_BUBBLES);
    end else if ((r_state == S_RESET) && (r_bub != '0)) begin
      r_bub <= r_bub - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_ld_main_new  = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      S_RESET: begin
        if (w_bub_done) w_next = S_EMPTY;
      end
      S_EMPTY: begin
        if (flush) begin
          w_next = S_EMPTY;
        end else if (w_accept) begin
          w_ld_main_new = 1'b1;
          w_next        = S_HALF;
        end
      end
      S_HALF: begin
        if (flush) begin
          w_next = S_EMPTY;
        end else if (w_accept && w_deliver) begin
          w_ld_main_new = 1'b1;
        end else if (w_accept) begin
          w_ld_skid = 1'b1;
          w_next    = S_FULL;
        end else if (w_deliver) begin
          w_next = S_EMPTY;
        end
      end
      S_FULL: begin
        if (flush) begin
          w_next = S_EMPTY;
        end else if (w_deliver) begin
          w_ld_main_skid = 1'b1;
          w_next         = S_HALF;
        end
      end
      default: w_next = S_RESET;
    endcase
  end

  // Entry storage: only written on a load, so fields hold while stalled.
  // No reset needed because every output field is qualified by out_valid.
  always_ff @(posedge clk) begin
    if (w_ld_main_new) begin
      r_main <= w_dec;
    end else if (w_ld_main_skid) begin
      r_main <= r_skid;
    end
    if (w_ld_skid) begin
      r_skid <= w_dec;
    end
  end

  // Saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready && (r_stall != {CNT_W{1'b1}})) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  // Qualifying by out_valid zeroes the fields on reset and flush at once.
  assign ig_en     = out_valid & r_main.en;
  assign ig_sel    = out_valid ? r_main.sel : 4'd0;
  assign ig_in     = out_valid ? r_main.imm : 25'd0;
  assign illegal   = out_valid & r_main.ill;
  assign stall_cnt = r_stall;

endmodule
